// File: rtl/arbiter.sv
// Two-master non-preemptive round-robin arbiter.
// Grants and priority pointer are Moore outputs of registered state.
module arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       request1,
    input  logic       request2,
    output logic       grant1,
    output logic       grant2,
    output logic [1:0] D_PRIORITY
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT1 = 2'b01,
        GNT2 = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] prio_q, prio_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 2'b01;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        unique case (state_q)
            IDLE: begin
                if (request1 && (!request2 || prio_q[0]))
                    state_d = GNT1;
                else if (request2)
                    state_d = GNT2;
            end
            GNT1: begin
                if (!request1)
                    state_d = request2 ? GNT2 : IDLE;
            end
            GNT2: begin
                if (!request2)
                    state_d = request1 ? GNT1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A fresh grant hands priority to the other master.
        if (state_d == GNT1 && state_q != GNT1)
            prio_d = 2'b10;
        else if (state_d == GNT2 && state_q != GNT2)
            prio_d = 2'b01;
    end

    always_comb begin
        grant1     = (state_q == GNT1);
        grant2     = (state_q == GNT2);
        D_PRIORITY = prio_q;
    end

endmodule

// File: tb/tb_arbiter.sv
// Directed and randomized checks for the round-robin arbiter.
module tb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       request1;
    logic       request2;
    logic       grant1;
    logic       grant2;
    logic [1:0] D_PRIORITY;

    int n_checks = 0;
    int n_fail   = 0;

    arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .request1   (request1),
        .request2   (request2),
        .grant1     (grant1),
        .grant2     (grant2),
        .D_PRIORITY (D_PRIORITY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got,
                         input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic r1, input logic r2);
        rst      = rs;
        request1 = r1;
        request2 = r2;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [1:0] g,
                                input logic [1:0] p);
        check({tag, "_grant"}, {grant1, grant2}, g);
        check({tag, "_prio"}, D_PRIORITY, p);
    endtask

    logic       m_g1, m_g2;
    logic [1:0] m_p;
    logic       rs, r1, r2;

    initial begin
        rst = 1'b1;
        request1 = 1'b0;
        request2 = 1'b0;

        // Reset with both requests high
        step(1, 1, 1);
        expect_state("rst0", 2'b00, 2'b01);
        step(1, 1, 1);
        expect_state("rst1", 2'b00, 2'b01);
        step(0, 1, 1);
        expect_state("rst_rel", 2'b10, 2'b10);
        step(0, 0, 0);
        expect_state("idle0", 2'b00, 2'b10);

        // Single master with late contender
        step(0, 1, 0);
        expect_state("single_g1", 2'b10, 2'b10);
        step(0, 1, 1);
        expect_state("no_preempt", 2'b10, 2'b10);
        step(0, 0, 1);
        expect_state("handoff", 2'b01, 2'b01);
        step(0, 0, 0);
        expect_state("idle1", 2'b00, 2'b01);

        // Simultaneous requests
        step(0, 1, 1);
        expect_state("simul", 2'b10, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            expect_state("simul_hold", 2'b10, 2'b10);
        end
        step(0, 0, 1);
        expect_state("simul_hand", 2'b01, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1);
            expect_state("g2_hold", 2'b01, 2'b01);
        end
        step(0, 0, 0);
        expect_state("idle2", 2'b00, 2'b01);

        // Move priority to master 2, then contend repeatedly
        step(0, 1, 0);
        expect_state("prep", 2'b10, 2'b10);
        step(0, 0, 0);
        expect_state("idle3", 2'b00, 2'b10);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1);
            if (i % 2 == 0)
                expect_state("rr_g2", 2'b01, 2'b01);
            else
                expect_state("rr_g1", 2'b10, 2'b10);
            step(0, 0, 0);
            expect_state("rr_idle", 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Reset mid-transfer
        step(0, 1, 1);
        expect_state("mid_g2", 2'b01, 2'b01);
        step(1, 1, 1);
        expect_state("mid_rst", 2'b00, 2'b01);
        step(0, 1, 1);
        expect_state("post_rst", 2'b10, 2'b10);

        // Randomized: reference model plus invariants
        m_g1 = 1'b1;
        m_g2 = 1'b0;
        m_p  = 2'b10;
        for (int c = 0; c < 1000; c++) begin
            rs = ($urandom_range(0, 49) == 0);
            r1 = $urandom_range(0, 1) == 1;
            r2 = $urandom_range(0, 1) == 1;
            step(rs, r1, r2);
            if (rs) begin
                m_g1 = 1'b0;
                m_g2 = 1'b0;
                m_p  = 2'b01;
            end else if (m_g1) begin
                if (!r1) begin
                    m_g1 = 1'b0;
                    m_g2 = r2;
                    if (r2) m_p = 2'b01;
                end
            end else if (m_g2) begin
                if (!r2) begin
                    m_g2 = 1'b0;
                    m_g1 = r1;
                    if (r1) m_p = 2'b10;
                end
            end else if (r1 && r2) begin
                m_g1 = (m_p == 2'b01);
                m_g2 = (m_p == 2'b10);
                m_p  = ~m_p;
            end else if (r1) begin
                m_g1 = 1'b1;
                m_p  = 2'b10;
            end else if (r2) begin
                m_g2 = 1'b1;
                m_p  = 2'b01;
            end
            check("rand_mutex", {1'b0, grant1 & grant2}, 2'b00);
            check("rand_onehot", {1'b0, ^D_PRIORITY}, 2'b01);
            check("rand_grant", {grant1, grant2}, {m_g1, m_g2});
            check("rand_prio", D_PRIORITY, m_p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
